// File: rtl/lcd_frame_writer.sv
// lcd_frame_writer: turns the PPU pixel stream into framebuffer writes.
// Tracks column/line position from HBlank/VBlank level changes, writes each
// visible pixel one cycle after it arrives, and flags malformed lines/frames.
module lcd_frame_writer #(
    parameter int H_PIXELS = 160,
    parameter int V_LINES  = 144
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        lcd_en_in,
    input  logic [1:0]  pixel_in,
    input  logic        pixel_valid_in,
    input  logic        hblank_in,
    input  logic        vblank_in,
    output logic [14:0] fb_addr_out,
    output logic [1:0]  fb_data_out,
    output logic        fb_we_out,
    output logic [7:0]  x_out,
    output logic [7:0]  y_out,
    output logic        frame_done_out,
    output logic        line_err_out,
    output logic        frame_err_out
);

    localparam logic [7:0]  H_MAX  = 8'(H_PIXELS);
    localparam logic [7:0]  V_MAX  = 8'(V_LINES);
    localparam logic [14:0] H_STEP = 15'(H_PIXELS);

    typedef enum logic [1:0] {SYNC, ACTIVE, HBLANK, VBLANK} state_t;

    state_t      state, state_nxt;
    logic [7:0]  x, x_nxt;
    logic [7:0]  y, y_nxt;
    logic [14:0] line_base, line_base_nxt;
    logic [14:0] addr_nxt;
    logic [1:0]  data_nxt;
    logic        we_nxt, done_nxt, line_err_nxt, frame_err_nxt;
    logic        hblank_q, vblank_q;
    logic        hb_rise, hb_fall, vb_rise, vb_fall;

    assign hb_rise = hblank_in & ~hblank_q;
    assign hb_fall = ~hblank_in & hblank_q;
    assign vb_rise = vblank_in & ~vblank_q;
    assign vb_fall = ~vblank_in & vblank_q;

    assign x_out = x;
    assign y_out = y;

    // State register; reset always lands in SYNC so we wait for a clean frame start
    always_ff @(posedge clk_in) begin
        if (rst_in)
            state <= SYNC;
        else
            state <= state_nxt;
    end

    // Counters, blank-edge history, write port and status flags
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            x              <= '0;
            y              <= '0;
            line_base      <= '0;
            hblank_q       <= 1'b0;
            vblank_q       <= 1'b0;
            fb_addr_out    <= '0;
            fb_data_out    <= '0;
            fb_we_out      <= 1'b0;
            frame_done_out <= 1'b0;
            line_err_out   <= 1'b0;
            frame_err_out  <= 1'b0;
        end else begin
            x              <= x_nxt;
            y              <= y_nxt;
            line_base      <= line_base_nxt;
            hblank_q       <= hblank_in;
            vblank_q       <= vblank_in;
            fb_addr_out    <= addr_nxt;
            fb_data_out    <= data_nxt;
            fb_we_out      <= we_nxt;
            frame_done_out <= done_nxt;
            line_err_out   <= line_err_nxt;
            frame_err_out  <= frame_err_nxt;
        end
    end

    // Next-state logic: pixel write first, then HBlank update, then VBlank check on updated y
    always_comb begin
        state_nxt     = state;
        x_nxt         = x;
        y_nxt         = y;
        line_base_nxt = line_base;
        addr_nxt      = fb_addr_out;
        data_nxt      = fb_data_out;
        we_nxt        = 1'b0;
        done_nxt      = 1'b0;
        line_err_nxt  = line_err_out;
        frame_err_nxt = frame_err_out;

        if (!lcd_en_in) begin
            state_nxt     = SYNC;
            x_nxt         = '0;
            y_nxt         = '0;
            line_base_nxt = '0;
        end else begin
            case (state)
                SYNC: begin
                    if (vb_rise)
                        state_nxt = VBLANK;
                end
                VBLANK: begin
                    if (vb_fall) begin
                        state_nxt     = ACTIVE;
                        x_nxt         = '0;
                        y_nxt         = '0;
                        line_base_nxt = '0;
                    end
                end
                ACTIVE: begin
                    if (pixel_valid_in) begin
                        if ((y == V_MAX) || (x == H_MAX)) begin
                            line_err_nxt = 1'b1;
                        end else begin
                            we_nxt   = 1'b1;
                            addr_nxt = line_base + {7'd0, x};
                            data_nxt = pixel_in;
                            x_nxt    = x + 8'd1;
                        end
                    end
                    if (hb_rise) begin
                        if (x_nxt != H_MAX)
                            line_err_nxt = 1'b1;
                        y_nxt         = y + 8'd1;
                        line_base_nxt = line_base + H_STEP;
                        x_nxt         = '0;
                        state_nxt     = HBLANK;
                    end
                    if (vb_rise) begin
                        if (y_nxt == V_MAX)
                            done_nxt = 1'b1;
                        else
                            frame_err_nxt = 1'b1;
                        state_nxt = VBLANK;
                    end
                end
                HBLANK: begin
                    if (vb_rise) begin
                        if (y == V_MAX)
                            done_nxt = 1'b1;
                        else
                            frame_err_nxt = 1'b1;
                        state_nxt = VBLANK;
                    end else if (hb_fall && !vblank_in) begin
                        state_nxt = ACTIVE;
                    end
                end
                default: state_nxt = SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Directed bench for lcd_frame_writer: one task per scenario, each checking inline.
module tb_lcd_frame_writer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        lcd_en_in;
    logic [1:0]  pixel_in;
    logic        pixel_valid_in;
    logic        hblank_in;
    logic        vblank_in;
    logic [14:0] fb_addr_out;
    logic [1:0]  fb_data_out;
    logic        fb_we_out;
    logic [7:0]  x_out;
    logic [7:0]  y_out;
    logic        frame_done_out;
    logic        line_err_out;
    logic        frame_err_out;

    int checks   = 0;
    int failures = 0;

    logic [14:0] wr_addr [0:65535];
    logic [1:0]  wr_data [0:65535];
    int          wr_count   = 0;
    int          done_count = 0;

    lcd_frame_writer dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .lcd_en_in      (lcd_en_in),
        .pixel_in       (pixel_in),
        .pixel_valid_in (pixel_valid_in),
        .hblank_in      (hblank_in),
        .vblank_in      (vblank_in),
        .fb_addr_out    (fb_addr_out),
        .fb_data_out    (fb_data_out),
        .fb_we_out      (fb_we_out),
        .x_out          (x_out),
        .y_out          (y_out),
        .frame_done_out (frame_done_out),
        .line_err_out   (line_err_out),
        .frame_err_out  (frame_err_out)
    );

    // 100 MHz clock
    always #5 clk_in = ~clk_in;

    // Log every framebuffer write and frame_done pulse, sampled mid-cycle
    always @(negedge clk_in) begin
        if (fb_we_out === 1'b1) begin
            wr_addr[wr_count] = fb_addr_out;
            wr_data[wr_count] = fb_data_out;
            wr_count++;
        end
        if (frame_done_out === 1'b1)
            done_count++;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        pixel_valid_in = 1'b0;
        pixel_in       = 2'd0;
        hblank_in      = 1'b0;
        vblank_in      = 1'b0;
    endtask

    task automatic do_reset();
        rst_in    = 1'b1;
        lcd_en_in = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic vblank_pulse();
        vblank_in = 1'b1;
        tick();
        tick();
        vblank_in = 1'b0;
        tick();
    endtask

    task automatic hblank_pulse();
        hblank_in = 1'b1;
        tick();
        tick();
        hblank_in = 1'b0;
        tick();
    endtask

    task automatic send_pixels(input int n, input logic [1:0] colour);
        for (int i = 0; i < n; i++) begin
            pixel_valid_in = 1'b1;
            pixel_in       = colour;
            tick();
        end
        pixel_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({fb_we_out, frame_done_out, line_err_out, frame_err_out} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected 0000",
                     {fb_we_out, frame_done_out, line_err_out, frame_err_out});
        end
        checks++;
        if ({x_out, y_out} !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_xy: got x=%0d y=%0d expected 0 0", x_out, y_out);
        end
        checks++;
        if ({fb_addr_out, fb_data_out} !== 17'd0) begin
            failures++;
            $display("[TB] FAIL reset_fb: got addr=%0d data=%0d expected 0 0", fb_addr_out, fb_data_out);
        end
    endtask

    task automatic test_no_vblank();
        int start;
        start = wr_count;
        send_pixels(20, 2'd2);
        hblank_pulse();
        send_pixels(20, 2'd1);
        tick();
        checks++;
        if (wr_count - start !== 0) begin
            failures++;
            $display("[TB] FAIL sync_writes: got %0d expected 0", wr_count - start);
        end
        checks++;
        if (x_out !== 8'd0) begin
            failures++;
            $display("[TB] FAIL sync_x: got %0d expected 0", x_out);
        end
    endtask

    task automatic test_full_frame();
        int start, d0, bad, line, col;
        logic [1:0] exp_data;
        start = wr_count;
        d0    = done_count;
        vblank_pulse();
        checks++;
        if (done_count - d0 !== 0) begin
            failures++;
            $display("[TB] FAIL sync_no_done: got %0d expected 0", done_count - d0);
        end
        for (int ln = 0; ln < 144; ln++) begin
            for (int c = 0; c < 160; c++) begin
                pixel_valid_in = 1'b1;
                pixel_in = (ln == 3 && c == 5) ? 2'b11 : 2'((ln + c) & 3);
                tick();
                if (ln == 3 && c == 5) begin
                    checks++;
                    if (fb_we_out !== 1'b1 || fb_addr_out !== 15'd485 || fb_data_out !== 2'd3) begin
                        failures++;
                        $display("[TB] FAIL latency_485: got we=%b addr=%0d data=%0d expected 1 485 3",
                                 fb_we_out, fb_addr_out, fb_data_out);
                    end
                end
            end
            pixel_valid_in = 1'b0;
            hblank_pulse();
            if (ln == 0) begin
                checks++;
                if (fb_we_out !== 1'b0 || y_out !== 8'd1) begin
                    failures++;
                    $display("[TB] FAIL idle_line0: got we=%b y=%0d expected 0 1", fb_we_out, y_out);
                end
            end
        end
        checks++;
        if (wr_count - start !== 23040) begin
            failures++;
            $display("[TB] FAIL frame_writes: got %0d expected 23040", wr_count - start);
        end
        bad = 0;
        for (int k = 0; k < 23040; k++) begin
            line = k / 160;
            col  = k % 160;
            exp_data = (line == 3 && col == 5) ? 2'b11 : 2'((line + col) & 3);
            if (wr_addr[start + k] !== 15'(k) || wr_data[start + k] !== exp_data)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("[TB] FAIL frame_order: got %0d bad writes expected 0", bad);
        end
        checks++;
        if (line_err_out !== 1'b0 || frame_err_out !== 1'b0 || y_out !== 8'd144) begin
            failures++;
            $display("[TB] FAIL frame_status: got lerr=%b ferr=%b y=%0d expected 0 0 144",
                     line_err_out, frame_err_out, y_out);
        end
        send_pixels(2, 2'd1);
        tick();
        checks++;
        if (wr_count - start !== 23040 || line_err_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL extra_line: got writes=%0d lerr=%b expected 23040 1",
                     wr_count - start, line_err_out);
        end
        vblank_in = 1'b1;
        tick();
        checks++;
        if (frame_done_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL done_high: got %b expected 1", frame_done_out);
        end
        tick();
        checks++;
        if (frame_done_out !== 1'b0 || done_count - d0 !== 1) begin
            failures++;
            $display("[TB] FAIL done_pulse: got done=%b pulses=%0d expected 0 1",
                     frame_done_out, done_count - d0);
        end
        vblank_in = 1'b0;
        tick();
    endtask

    task automatic test_long_line();
        int start;
        do_reset();
        vblank_pulse();
        start = wr_count;
        send_pixels(161, 2'd2);
        tick();
        checks++;
        if (wr_count - start !== 160 || line_err_out !== 1'b1 || x_out !== 8'd160) begin
            failures++;
            $display("[TB] FAIL long_line: got writes=%0d lerr=%b x=%0d expected 160 1 160",
                     wr_count - start, line_err_out, x_out);
        end
        hblank_pulse();
        send_pixels(5, 2'd1);
        tick();
        checks++;
        if (wr_count - start !== 165 || wr_addr[start + 160] !== 15'd160 || wr_addr[start + 164] !== 15'd164) begin
            failures++;
            $display("[TB] FAIL next_line_addr: got writes=%0d first=%0d last=%0d expected 165 160 164",
                     wr_count - start, wr_addr[start + 160], wr_addr[start + 164]);
        end
    endtask

    task automatic test_short_frame();
        int d0;
        do_reset();
        vblank_pulse();
        d0 = done_count;
        repeat (100) hblank_pulse();
        checks++;
        if (y_out !== 8'd100) begin
            failures++;
            $display("[TB] FAIL short_y: got %0d expected 100", y_out);
        end
        vblank_in = 1'b1;
        tick();
        checks++;
        if (frame_err_out !== 1'b1 || frame_done_out !== 1'b0 || line_err_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL short_frame: got ferr=%b done=%b lerr=%b expected 1 0 1",
                     frame_err_out, frame_done_out, line_err_out);
        end
        tick();
        vblank_in = 1'b0;
        tick();
        checks++;
        if (done_count - d0 !== 0) begin
            failures++;
            $display("[TB] FAIL short_no_done: got %0d expected 0", done_count - d0);
        end
    endtask

    task automatic test_lcd_disable();
        int start, start2;
        do_reset();
        vblank_pulse();
        start = wr_count;
        send_pixels(50, 2'd1);
        lcd_en_in      = 1'b0;
        pixel_valid_in = 1'b1;
        tick();
        checks++;
        if (fb_we_out !== 1'b0 || x_out !== 8'd0 || wr_count - start !== 50) begin
            failures++;
            $display("[TB] FAIL lcd_off: got we=%b x=%0d writes=%0d expected 0 0 50",
                     fb_we_out, x_out, wr_count - start);
        end
        pixel_valid_in = 1'b0;
        lcd_en_in      = 1'b1;
        send_pixels(30, 2'd2);
        hblank_pulse();
        checks++;
        if (wr_count - start !== 50) begin
            failures++;
            $display("[TB] FAIL lcd_resync: got %0d expected 50", wr_count - start);
        end
        vblank_pulse();
        start2 = wr_count;
        send_pixels(160, 2'd3);
        hblank_pulse();
        send_pixels(160, 2'd0);
        tick();
        checks++;
        if (wr_count - start2 !== 320 || wr_addr[start2] !== 15'd0 || wr_addr[start2 + 319] !== 15'd319) begin
            failures++;
            $display("[TB] FAIL lcd_restart: got writes=%0d first=%0d last=%0d expected 320 0 319",
                     wr_count - start2, wr_addr[start2], wr_addr[start2 + 319]);
        end
        send_pixels(1, 2'd1);
        lcd_en_in = 1'b0;
        tick();
        checks++;
        if (line_err_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL err_held: got %b expected 1", line_err_out);
        end
        lcd_en_in = 1'b1;
        tick();
    endtask

    task automatic test_reset_abort();
        int start;
        vblank_pulse();
        send_pixels(10, 2'd2);
        rst_in         = 1'b1;
        pixel_valid_in = 1'b1;
        tick();
        checks++;
        if (fb_we_out !== 1'b0 || line_err_out !== 1'b0 || x_out !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_abort: got we=%b lerr=%b x=%0d expected 0 0 0",
                     fb_we_out, line_err_out, x_out);
        end
        rst_in = 1'b0;
        start  = wr_count;
        send_pixels(10, 2'd1);
        tick();
        checks++;
        if (wr_count - start !== 0) begin
            failures++;
            $display("[TB] FAIL post_reset_writes: got %0d expected 0", wr_count - start);
        end
    endtask

    task automatic test_simul_edges();
        do_reset();
        vblank_pulse();
        send_pixels(160, 2'd1);
        hblank_pulse();
        send_pixels(160, 2'd2);
        hblank_in = 1'b1;
        vblank_in = 1'b1;
        tick();
        checks++;
        if (y_out !== 8'd2 || line_err_out !== 1'b0 || frame_err_out !== 1'b1 || frame_done_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL simul_edges: got y=%0d lerr=%b ferr=%b done=%b expected 2 0 1 0",
                     y_out, line_err_out, frame_err_out, frame_done_out);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        rst_in    = 1'b1;
        lcd_en_in = 1'b1;
        idle_inputs();
        test_reset();
        test_no_vblank();
        test_full_frame();
        test_long_line();
        test_short_frame();
        test_lcd_disable();
        test_reset_abort();
        test_simul_edges();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_frame_writer.md
LCD_FRAME_WRITER -- requirements
Module: lcd_frame_writer

Interface
REQ-001 Parameter H_PIXELS, default 160: pixels per visible scanline.
REQ-002 Parameter V_LINES, default 144: visible scanlines per frame.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk_in, input, 1: system clock, 100 MHz.
REQ-005 Port rst_in, input, 1: synchronous active-high reset.
REQ-006 Port lcd_en_in, input, 1: LCD enable, LCDC bit 7.
REQ-007 Port pixel_in, input, 2: PPU colour index.
REQ-008 Port pixel_valid_in, input, 1: pixel_in is valid this cycle.
REQ-009 Port hblank_in, input, 1: PPU is in HBlank, level signal.
REQ-010 Port vblank_in, input, 1: PPU is in VBlank, level signal.
REQ-011 Port fb_addr_out, output, 15: framebuffer write address, y*H_PIXELS+x.
REQ-012 Port fb_data_out, output, 2: framebuffer write data.
REQ-013 Port fb_we_out, output, 1: framebuffer write strobe.
REQ-014 Port x_out, output, 8: current column count.
REQ-015 Port y_out, output, 8: current line count.
REQ-016 Port frame_done_out, output, 1: one-cycle pulse when a complete frame has been written.
REQ-017 Port line_err_out, output, 1: sticky flag for a short or overlong line.
REQ-018 Port frame_err_out, output, 1: sticky flag for a short frame.

Function
REQ-019 FSM states: SYNC, ACTIVE, HBLANK, VBLANK.
REQ-020 SYNC: discard all pixels; on a vblank_in rising edge, go to VBLANK without asserting frame_done_out.
REQ-021 VBLANK: on a vblank_in falling edge, go to ACTIVE with x=0, y=0, line_base=0.
REQ-022 ACTIVE, pixel_valid_in=1, x<H_PIXELS, next cycle: fb_we_out=1, fb_addr_out=line_base+x, fb_data_out=pixel_in; x increments.
REQ-023 Write latency SHALL be exactly 1 cycle; fb_we_out SHALL be 0 on every cycle without a write.
REQ-024 ACTIVE, pixel_valid_in=1, x==H_PIXELS: drop the pixel, do not write, set line_err_out; x saturates.
REQ-025 ACTIVE, hblank_in rising edge: if x!=H_PIXELS, set line_err_out; then y+=1, line_base+=H_PIXELS, x=0, go to HBLANK.
REQ-026 line_base SHALL be a running-sum register; no multiplier; 15-bit width, no wrap within V_LINES*H_PIXELS (max 23039).
REQ-027 HBLANK: ignore pixels; on a hblank_in falling edge with vblank_in=0, go to ACTIVE.
REQ-028 ACTIVE or HBLANK, vblank_in rising edge: go to VBLANK; pulse frame_done_out for 1 cycle if y==V_LINES, else set frame_err_out.
REQ-029 A hblank_in rising edge and a vblank_in rising edge in the same cycle: apply the hblank update first, then evaluate y for REQ-028.
REQ-030 ACTIVE, y==V_LINES with pixel_valid_in=1: drop the pixel and set line_err_out.
REQ-031 Edges SHALL be detected against registered copies of hblank_in and vblank_in.
REQ-032 lcd_en_in=0, any state: next state SYNC; x, y, and line_base cleared; fb_we_out=0; error flags held.
REQ-033 x_out and y_out SHALL reflect the registered counters.

Reset
REQ-034 rst_in=1, next cycle: state=SYNC; x, y, line_base, fb_addr_out, fb_data_out=0; fb_we_out, frame_done_out, line_err_out, frame_err_out=0.
REQ-035 Reset SHALL abort mid-line or mid-frame with no write issued on the following cycle.
REQ-036 Error flags SHALL clear only on rst_in.

Verification
REQ-037 Sequence: vblank pulse, then 144 lines of 160 valid pixels, each followed by hblank, then vblank -> 23040 writes with addresses 0..23039 in order, one frame_done_out pulse, no error flags.
REQ-038 Pixel 2'b11 at line 3, column 5 -> fb_addr_out=485, fb_data_out=3, fb_we_out high one cycle after pixel_valid_in.
REQ-039 Line with 161 valid pixels -> 160 writes, line_err_out=1, next line starts at address line_base+160.
REQ-040 vblank_in rises after 100 lines -> frame_err_out=1, no frame_done_out pulse.
REQ-041 Pixels arrive before the first vblank after reset -> zero writes.
REQ-042 lcd_en_in dropped mid-line, then a full frame -> no writes until the next vblank; the next frame starts at address 0.
